// File: rtl/arythcrypt_result_fifo.sv
// arythcrypt_result_fifo: tagged result FIFO behind the crypto core, with a registered pop port and a sticky overflow flag.
// Optional build macro ARYTHCRYPT_FIFO_CHECKSUM_EN adds a running XOR of the accepted results.
module arythcrypt_result_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int TAGW  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         res_in,
    input  logic [TAGW-1:0]          tag_in,
    input  logic                     res_valid,
    input  logic                     rd_en,
    input  logic                     ovf_clr,
    output logic [WIDTH-1:0]         dout,
    output logic [TAGW-1:0]          tag_out,
    output logic                     dout_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic [WIDTH-1:0]         checksum
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = TAGW + WIDTH;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [TAGW-1:0]  tag_q, tag_d;
    logic             dout_valid_q, dout_valid_d;
    logic             ovf_q, ovf_d;
    logic             pop_ok, wr_ok, drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Handshake decode; a pop on a full FIFO frees the slot the concurrent write lands in
    always_comb begin
        pop_ok = rd_en && !empty;
        wr_ok  = res_valid && (!full || pop_ok);
        drop   = res_valid && full && !pop_ok;
    end

    // Next state for pointers, occupancy, pop port and overflow flag
    always_comb begin
        wr_ptr_d     = wr_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d     = pop_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d      = (wr_ok && !pop_ok) ? count_q + CW'(1) :
                       (pop_ok && !wr_ok) ? count_q - CW'(1) : count_q;
        {tag_d, dout_d} = pop_ok ? mem_q[rd_ptr_q] : {tag_q, dout_q};
        dout_valid_d = pop_ok;
        ovf_d        = drop ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
    end

    // Storage array; not cleared by reset, the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= {tag_in, res_in};
    end

    // Control and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            tag_q        <= '0;
            dout_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            tag_q        <= tag_d;
            dout_valid_q <= dout_valid_d;
            ovf_q        <= ovf_d;
        end
    end

`ifdef ARYTHCRYPT_FIFO_CHECKSUM_EN
    logic [WIDTH-1:0] checksum_q, checksum_d;

    // Fold each accepted result into the checksum; dropped writes never reach it
    always_comb begin
        checksum_d = wr_ok ? checksum_q ^ res_in : checksum_q;
    end

    // Checksum register, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) checksum_q <= '0;
        else        checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign dout       = dout_q;
    assign tag_out    = tag_q;
    assign dout_valid = dout_valid_q;
    assign count      = count_q;
    assign ovf        = ovf_q;
endmodule

// File: tb/tb_arythcrypt_result_fifo.sv
// tb_arythcrypt_result_fifo: directed vector bench for the tagged result FIFO.
module tb_arythcrypt_result_fifo;
    typedef struct {
        logic       rn, wv;
        logic [7:0] wd;
        logic [3:0] wt;
        logic       rd, clr;
        logic [3:0] cnt;
        logic       ovf, dv;
        logic [7:0] dout;
        logic [3:0] tag;
        logic [7:0] ck;
    } vec_t;

    logic       clk = 0;
    logic       rst_n = 1;
    logic [7:0] res_in = 0;
    logic [3:0] tag_in = 0;
    logic       res_valid = 0, rd_en = 0, ovf_clr = 0;
    logic [7:0] dout, checksum;
    logic [3:0] tag_out, count;
    logic       dout_valid, empty, full, ovf;

    int nvec = 0;
    int nbad = 0;
    vec_t tbl[$];
    logic [7:0] ck_m;
    logic [7:0] vals[12];

    arythcrypt_result_fifo dut (
        .clk(clk), .rst_n(rst_n), .res_in(res_in), .tag_in(tag_in),
        .res_valid(res_valid), .rd_en(rd_en), .ovf_clr(ovf_clr),
        .dout(dout), .tag_out(tag_out), .dout_valid(dout_valid),
        .empty(empty), .full(full), .count(count), .ovf(ovf), .checksum(checksum)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rn, logic wv, logic [7:0] wd, logic [3:0] wt, logic rd, logic clr,
                                logic [3:0] cnt, logic ovf_e, logic dv, logic [7:0] d, logic [3:0] t, logic [7:0] ck);
        vec_t v;
        v.rn = rn; v.wv = wv; v.wd = wd; v.wt = wt; v.rd = rd; v.clr = clr;
        v.cnt = cnt; v.ovf = ovf_e; v.dv = dv; v.dout = d; v.tag = t; v.ck = ck;
        return v;
    endfunction

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        if (act !== exp) begin
            nbad++;
            $display("FAIL vec %0d %s: got %h expected %h", nvec, nm, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        logic [7:0] ck_e;
        @(negedge clk);
        rst_n = v.rn; res_valid = v.wv; res_in = v.wd; tag_in = v.wt; rd_en = v.rd; ovf_clr = v.clr;
        @(posedge clk);
        #1;
`ifdef ARYTHCRYPT_FIFO_CHECKSUM_EN
        ck_e = v.ck;
`else
        ck_e = 8'h00;
`endif
        nvec++;
        chk("count", {4'h0, count}, {4'h0, v.cnt});
        chk("empty", {7'h0, empty}, {7'h0, v.cnt == 4'd0});
        chk("full", {7'h0, full}, {7'h0, v.cnt == 4'd8});
        chk("ovf", {7'h0, ovf}, {7'h0, v.ovf});
        chk("dout_valid", {7'h0, dout_valid}, {7'h0, v.dv});
        chk("dout", dout, v.dout);
        chk("tag_out", {4'h0, tag_out}, {4'h0, v.tag});
        chk("checksum", checksum, ck_e);
        rst_n = 1; res_valid = 0; rd_en = 0; ovf_clr = 0;
    endtask

    initial begin
        // Test 1: three tagged writes, three pops, then empty-pop ignored
        tbl.push_back(mk(0,0,8'h00,0,0,0, 0,0,0,8'h00,0,8'h00));
        tbl.push_back(mk(1,1,8'h11,1,0,0, 1,0,0,8'h00,0,8'h11));
        tbl.push_back(mk(1,1,8'h22,2,0,0, 2,0,0,8'h00,0,8'h33));
        tbl.push_back(mk(1,1,8'h33,3,0,0, 3,0,0,8'h00,0,8'h00));
        tbl.push_back(mk(1,0,8'h00,0,1,0, 2,0,1,8'h11,1,8'h00));
        tbl.push_back(mk(1,0,8'h00,0,1,0, 1,0,1,8'h22,2,8'h00));
        tbl.push_back(mk(1,0,8'h00,0,1,0, 0,0,1,8'h33,3,8'h00));
        tbl.push_back(mk(1,0,8'h00,0,0,0, 0,0,0,8'h33,3,8'h00));
        tbl.push_back(mk(1,0,8'h00,0,1,0, 0,0,0,8'h33,3,8'h00));
        // Test 2: fill 0x00..0x07, dropped 9th write, drain in order
        tbl.push_back(mk(1,1,8'h00,0,0,0, 1,0,0,8'h33,3,8'h00));
        tbl.push_back(mk(1,1,8'h01,1,0,0, 2,0,0,8'h33,3,8'h01));
        tbl.push_back(mk(1,1,8'h02,2,0,0, 3,0,0,8'h33,3,8'h03));
        tbl.push_back(mk(1,1,8'h03,3,0,0, 4,0,0,8'h33,3,8'h00));
        tbl.push_back(mk(1,1,8'h04,4,0,0, 5,0,0,8'h33,3,8'h04));
        tbl.push_back(mk(1,1,8'h05,5,0,0, 6,0,0,8'h33,3,8'h01));
        tbl.push_back(mk(1,1,8'h06,6,0,0, 7,0,0,8'h33,3,8'h07));
        tbl.push_back(mk(1,1,8'h07,7,0,0, 8,0,0,8'h33,3,8'h00));
        tbl.push_back(mk(1,1,8'hAA,15,0,0, 8,1,0,8'h33,3,8'h00));
        tbl.push_back(mk(1,0,8'h00,0,1,0, 7,1,1,8'h00,0,8'h00));
        tbl.push_back(mk(1,0,8'h00,0,1,0, 6,1,1,8'h01,1,8'h00));
        tbl.push_back(mk(1,0,8'h00,0,1,0, 5,1,1,8'h02,2,8'h00));
        tbl.push_back(mk(1,0,8'h00,0,1,0, 4,1,1,8'h03,3,8'h00));
        tbl.push_back(mk(1,0,8'h00,0,1,0, 3,1,1,8'h04,4,8'h00));
        tbl.push_back(mk(1,0,8'h00,0,1,0, 2,1,1,8'h05,5,8'h00));
        tbl.push_back(mk(1,0,8'h00,0,1,0, 1,1,1,8'h06,6,8'h00));
        tbl.push_back(mk(1,0,8'h00,0,1,0, 0,1,1,8'h07,7,8'h00));
        tbl.push_back(mk(1,0,8'h00,0,1,0, 0,1,0,8'h07,7,8'h00));
        tbl.push_back(mk(1,0,8'h00,0,0,1, 0,0,0,8'h07,7,8'h00));
        // Test 3: fill 0x80..0x87, then write 0x5C with a pop on full
        tbl.push_back(mk(1,1,8'h80,0,0,0, 1,0,0,8'h07,7,8'h80));
        tbl.push_back(mk(1,1,8'h81,1,0,0, 2,0,0,8'h07,7,8'h01));
        tbl.push_back(mk(1,1,8'h82,2,0,0, 3,0,0,8'h07,7,8'h83));
        tbl.push_back(mk(1,1,8'h83,3,0,0, 4,0,0,8'h07,7,8'h00));
        tbl.push_back(mk(1,1,8'h84,4,0,0, 5,0,0,8'h07,7,8'h84));
        tbl.push_back(mk(1,1,8'h85,5,0,0, 6,0,0,8'h07,7,8'h01));
        tbl.push_back(mk(1,1,8'h86,6,0,0, 7,0,0,8'h07,7,8'h87));
        tbl.push_back(mk(1,1,8'h87,7,0,0, 8,0,0,8'h07,7,8'h00));
        tbl.push_back(mk(1,1,8'h5C,12,1,0, 8,0,1,8'h80,0,8'h5C));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Test 3 drain: 0x81..0x87 then 0x5C last
        for (int i = 1; i < 8; i++) apply(mk(1,0,8'h00,0,1,0, 4'(8-i),0,1,8'h80+8'(i),4'(i),8'h5C));
        apply(mk(1,0,8'h00,0,1,0, 0,0,1,8'h5C,12,8'h5C));

        // Test 4: write+pop on empty lands the write only, no bypass
        apply(mk(1,1,8'h3E,14,1,0, 1,0,0,8'h5C,12,8'h62));
        apply(mk(1,0,8'h00,0,1,0, 0,0,1,8'h3E,14,8'h62));

        // Test 5: 12 values streamed with one-deep overlap so the pointers wrap
        ck_m = 8'h62;
        for (int i = 0; i < 12; i++) vals[i] = 8'(i * 37 + 5);
        ck_m ^= vals[0];
        apply(mk(1,1,vals[0],0,0,0, 1,0,0,8'h3E,14,ck_m));
        for (int i = 1; i < 12; i++) begin
            ck_m ^= vals[i];
            apply(mk(1,1,vals[i],4'(i),1,0, 1,0,1,vals[i-1],4'(i-1),ck_m));
        end
        apply(mk(1,0,8'h00,0,1,0, 0,0,1,vals[11],11,ck_m));

        // Test 6: fill, drop coinciding with clear keeps ovf, pop to 5, reset wipes all
        for (int i = 0; i < 8; i++) begin
            ck_m ^= 8'hC0 + 8'(i);
            apply(mk(1,1,8'hC0+8'(i),4'(i),0,0, 4'(i+1),0,0,vals[11],11,ck_m));
        end
        apply(mk(1,1,8'hFF,15,0,1, 8,1,0,vals[11],11,ck_m));
        for (int i = 0; i < 3; i++) apply(mk(1,0,8'h00,0,1,0, 4'(7-i),1,1,8'hC0+8'(i),4'(i),ck_m));
        apply(mk(0,0,8'h00,0,0,0, 0,0,0,8'h00,0,8'h00));
        apply(mk(1,0,8'h00,0,1,0, 0,0,0,8'h00,0,8'h00));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
